// File: rtl/pulse_blink.sv
// Stretches single-cycle event pulses into visible LED blinks (ON_CYCLES high, OFF_CYCLES low).
// Events arriving mid-blink queue in a saturating pending counter and replay back-to-back.
module pulse_blink #(
  parameter int ON_CYCLES  = 5_000_000,
  parameter int OFF_CYCLES = 5_000_000,
  parameter int CNT_W      = 24,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovf;
  logic              r_led;
  logic              r_busy;

  logic w_pend_nz;
  logic w_sat;
  logic w_consume;
  logic w_accept;
  logic w_drop;

  assign w_pend_nz = |r_pend;
  assign w_sat     = &r_pend;
  // A consume frees a slot on the same edge, so a pulse at saturation is still accepted then.
  assign w_consume = w_pend_nz &&
                     ((r_state == S_IDLE) || (r_state == S_OFF && r_cnt == OFF_LAST));
  assign w_accept  = pulse_in && (!w_sat || w_consume);
  assign w_drop    = pulse_in && w_sat && !w_consume;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (w_accept && !w_consume)      r_pend <= r_pend + PEND_W'(1);
      else if (w_consume && !w_accept) r_pend <= r_pend - PEND_W'(1);
      if (w_drop) r_ovf <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_pend_nz) begin
            r_state <= S_ON;
            r_cnt   <= '0;
            r_led   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_ON: begin
          if (r_cnt == ON_LAST) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_led   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_OFF: begin
          if (r_cnt == OFF_LAST) begin
            r_cnt <= '0;
            if (w_pend_nz) begin
              r_state <= S_ON;
              r_led   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign led      = r_led;
  assign busy     = r_busy;
  assign pending  = r_pend;
  assign overflow = r_ovf;

endmodule
